vec_mem_stage: RTL and testbench

VEC_MEM_STAGE -- requirements
Module: vec_mem_stage

---
 rtl/vp_pkg.sv | 16 +
 rtl/vlane_buffer.sv | 47 ++++
 rtl/vec_mem_stage.sv | 137 +++++++++++++
 tb/tb_vec_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared constants and FSM state encoding for the vector memory stage.
package vp_pkg;

    localparam int unsigned NLANES     = 8;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned VEC_W      = NLANES * LANE_W;
    localparam int unsigned LANE_IDX_W = $clog2(NLANES);

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StScalar = 2'd1;
    localparam state_t StVec    = 2'd2;
    localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/vlane_buffer.sv
// Vector lane buffer: collects one 32-bit word per lane, indexed by an internal lane counter.
module vlane_buffer
    import vp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic                  wr_en_i,
    input  logic [LANE_W-1:0]     wdata_i,
    output logic [LANE_IDX_W-1:0] lane_o,
    output logic [VEC_W-1:0]      data_o
);

    logic [LANE_IDX_W-1:0] lane_q, lane_d;
    logic [VEC_W-1:0]      buf_q, buf_d;

    // Writes land in the current lane; the counter advances on every accepted beat.
    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        if (clr_i) begin
            lane_d = '0;
        end else if (adv_i) begin
            for (int unsigned k = 0; k < NLANES; k++) begin
                if (wr_en_i && lane_q == LANE_IDX_W'(k)) begin
                    buf_d[k*LANE_W +: LANE_W] = wdata_i;
                end
            end
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

    assign lane_o = lane_q;
    assign data_o = buf_q;

endmodule

// File: rtl/vec_mem_stage.sv
// MEM pipeline stage: scalar and per-lane vector memory accesses with upstream stall,
// zero-latency pass-through for non-memory instructions.
module vec_mem_stage
    import vp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              VRegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              VLoad_i,
    input  logic              VStore_i,
    input  logic [4:0]        write_addr_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [VEC_W-1:0]  vdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              VRegWrite_o,
    output logic [4:0]        write_addr_o,
    output logic [31:0]       alu_result_o,
    output logic [VEC_W-1:0]  vresult_o,
    output logic              stall_o
);

    state_t                state_q, state_d;
    logic [LANE_W-1:0]     load_q, load_d;
    logic [LANE_IDX_W-1:0] lane;
    logic [VEC_W-1:0]      lane_buf;
    logic [LANE_W-1:0]     lane_wdata;
    logic                  mem_op, vec_op, last_lane;
    logic                  buf_clr, buf_adv, buf_wr;

    assign mem_op    = valid_i & (MemRead_i | MemWrite_i | VLoad_i | VStore_i);
    assign vec_op    = VLoad_i | VStore_i;
    assign last_lane = (lane == LANE_IDX_W'(NLANES - 1));
    assign buf_clr   = (state_q == StIdle);
    assign buf_adv   = (state_q == StVec) & mem_ack_i;
    assign buf_wr    = buf_adv & VLoad_i;

    always_comb begin
        lane_wdata = '0;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (lane == LANE_IDX_W'(k)) lane_wdata = vdata_i[k*LANE_W +: LANE_W];
        end
    end

    vlane_buffer u_vlane_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (buf_clr),
        .adv_i   (buf_adv),
        .wr_en_i (buf_wr),
        .wdata_i (mem_rdata_i),
        .lane_o  (lane),
        .data_o  (lane_buf)
    );

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        stall_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        RegWrite_o   = valid_i & RegWrite_i;
        MemtoReg_o   = valid_i & MemtoReg_i;
        VRegWrite_o  = valid_i & VRegWrite_i;
        write_addr_o = write_addr_i;
        alu_result_o = alu_result_i;
        vresult_o    = vdata_i;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall_o     = 1'b1;
                    RegWrite_o  = 1'b0;
                    VRegWrite_o = 1'b0;
                    MemtoReg_o  = 1'b0;
                    state_d     = vec_op ? StVec : StScalar;
                end
            end
            StScalar: begin
                stall_o     = 1'b1;
                RegWrite_o  = 1'b0;
                VRegWrite_o = 1'b0;
                MemtoReg_o  = 1'b0;
                mem_req_o   = 1'b1;
                mem_we_o    = MemWrite_i;
                mem_addr_o  = alu_result_i;
                mem_wdata_o = store_data_i;
                if (mem_ack_i) begin
                    if (MemRead_i) load_d = mem_rdata_i;
                    state_d = StDone;
                end
            end
            StVec: begin
                stall_o     = 1'b1;
                RegWrite_o  = 1'b0;
                VRegWrite_o = 1'b0;
                MemtoReg_o  = 1'b0;
                mem_req_o   = 1'b1;
                mem_we_o    = VStore_i;
                // Byte address of the current lane; wraps naturally at 2^32.
                mem_addr_o  = alu_result_i + {{(32 - LANE_IDX_W - 2){1'b0}}, lane, 2'b00};
                mem_wdata_o = lane_wdata;
                if (mem_ack_i && last_lane) state_d = StDone;
            end
            StDone: begin
                if (MemRead_i) alu_result_o = load_q;
                if (VLoad_i)   vresult_o    = lane_buf;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Randomized bench for vec_mem_stage with a transaction-level reference model.
module tb_vec_mem_stage;
    import vp_pkg::*;

    logic clk, rst_n;
    logic valid_i, RegWrite_i, MemtoReg_i, VRegWrite_i, MemRead_i, MemWrite_i, VLoad_i, VStore_i;
    logic [4:0] write_addr_i;
    logic [31:0] alu_result_i, store_data_i, mem_rdata_i;
    logic [255:0] vdata_i;
    logic mem_ack_i;
    logic mem_req_o, mem_we_o, RegWrite_o, MemtoReg_o, VRegWrite_o, stall_o;
    logic [31:0] mem_addr_o, mem_wdata_o, alu_result_o;
    logic [4:0] write_addr_o;
    logic [255:0] vresult_o;

    vec_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .VRegWrite_i(VRegWrite_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .VLoad_i(VLoad_i), .VStore_i(VStore_i),
        .write_addr_i(write_addr_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .vdata_i(vdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .VRegWrite_o(VRegWrite_o),
        .write_addr_o(write_addr_o), .alu_result_o(alu_result_o), .vresult_o(vresult_o),
        .stall_o(stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model expectations for the current cycle
    logic chk_en = 1'b0;
    logic e_stall, e_req, e_rw, e_vrw, e_mtr, e_mtr_chk, e_fld_chk, e_we;
    logic [31:0] e_addr, e_wdata, e_alu;
    logic [4:0] e_waddr;
    logic [255:0] e_vres;

    // Observations for the directed literal checks
    logic [31:0] obs_addr[$];
    logic [31:0] obs_wdata[$];
    logic obs_we[$];
    int stall_cnt, vrw_in_stall;
    logic last_rw, last_mtr, last_vrw, last_req;
    logic [31:0] last_alu;
    logic [255:0] last_vres;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 256'(stall_o), 256'(e_stall));
            chk("mem_req", 256'(mem_req_o), 256'(e_req));
            chk("RegWrite", 256'(RegWrite_o), 256'(e_rw));
            chk("VRegWrite", 256'(VRegWrite_o), 256'(e_vrw));
            if (e_mtr_chk) chk("MemtoReg", 256'(MemtoReg_o), 256'(e_mtr));
            if (!e_stall) begin
                chk("write_addr", 256'(write_addr_o), 256'(e_waddr));
                chk("alu_result", 256'(alu_result_o), 256'(e_alu));
                chk("vresult", vresult_o, e_vres);
            end
            if (e_fld_chk) begin
                chk("mem_we", 256'(mem_we_o), 256'(e_we));
                chk("mem_addr", 256'(mem_addr_o), 256'(e_addr));
                chk("mem_wdata", 256'(mem_wdata_o), 256'(e_wdata));
            end
            if (stall_o) stall_cnt++;
            if (stall_o && VRegWrite_o) vrw_in_stall++;
            if (!stall_o) begin
                last_rw   = RegWrite_o;
                last_mtr  = MemtoReg_o;
                last_vrw  = VRegWrite_o;
                last_req  = mem_req_o;
                last_alu  = alu_result_o;
                last_vres = vresult_o;
            end
            if (mem_req_o && mem_ack_i) begin
                obs_addr.push_back(mem_addr_o);
                obs_wdata.push_back(mem_wdata_o);
                obs_we.push_back(mem_we_o);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_obs();
        obs_addr.delete();
        obs_wdata.delete();
        obs_we.delete();
        stall_cnt = 0;
        vrw_in_stall = 0;
    endtask

    task automatic idle(input logic ack);
        valid_i = 1'b0;
        {RegWrite_i, MemtoReg_i, VRegWrite_i, MemRead_i, MemWrite_i, VLoad_i, VStore_i} = 7'($urandom);
        write_addr_i = 5'($urandom);
        alu_result_i = $urandom;
        store_data_i = $urandom;
        vdata_i      = rand256();
        mem_ack_i    = ack;
        mem_rdata_i  = $urandom;
        e_stall = 0; e_req = 0; e_rw = 0; e_vrw = 0; e_mtr = 0; e_mtr_chk = 1;
        e_fld_chk = 1; e_we = 0; e_addr = '0; e_wdata = '0;
        e_waddr = write_addr_i; e_alu = alu_result_i; e_vres = vdata_i;
        chk_en = 1'b1;
        cyc();
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 vload, 4 vstore. gap<0 picks random ack delays.
    // rst_at>=0 pulses reset just before the beat with that index.
    task automatic do_op(input int kind, input logic [31:0] base, input logic [31:0] sdata,
                         input logic [255:0] vd, input logic [4:0] wa, input logic rw,
                         input logic mtr, input logic vrw, input int gap,
                         input logic [31:0] rd_base, input logic rd_rand, input int rst_at);
        int n, g;
        logic [31:0] rd, loaded0;
        logic [255:0] loaded_vec;
        valid_i = 1'b1;
        MemRead_i = (kind == 1); MemWrite_i = (kind == 2);
        VLoad_i = (kind == 3); VStore_i = (kind == 4);
        RegWrite_i = rw; MemtoReg_i = mtr; VRegWrite_i = vrw; write_addr_i = wa;
        alu_result_i = base; store_data_i = sdata; vdata_i = vd;
        mem_ack_i = 1'($urandom_range(1, 0));
        mem_rdata_i = $urandom;
        chk_en = 1'b1;
        e_waddr = wa; e_alu = base; e_vres = vd; e_mtr = mtr; e_mtr_chk = 1; e_fld_chk = 0;
        loaded0 = '0;
        loaded_vec = '0;
        if (kind == 0) begin
            e_stall = 0; e_req = 0; e_rw = rw; e_vrw = vrw;
            cyc();
            return;
        end
        n = (kind >= 3) ? NLANES : 1;
        e_stall = 1; e_req = 0; e_rw = 0; e_vrw = 0; e_mtr_chk = 0;
        cyc();
        e_mtr = 0; e_mtr_chk = 1; e_req = 1; e_fld_chk = 1;
        e_we = (kind == 2 || kind == 4);
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                chk_en = 1'b0;
                mem_ack_i = 1'b0;
                cyc();
                rst_n = 1'b1;
                idle(1'b1);
                return;
            end
            e_addr  = base + 32'(4 * k);
            e_wdata = (kind >= 3) ? vd[k*32 +: 32] : sdata;
            g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
            repeat (g) begin
                mem_ack_i = 1'b0;
                mem_rdata_i = $urandom;
                cyc();
            end
            rd = rd_rand ? $urandom : rd_base + 32'(k);
            mem_ack_i = 1'b1;
            mem_rdata_i = rd;
            if (k == 0) loaded0 = rd;
            loaded_vec[k*32 +: 32] = rd;
            cyc();
        end
        mem_ack_i = 1'($urandom_range(1, 0));
        mem_rdata_i = $urandom;
        e_stall = 0; e_req = 0; e_fld_chk = 0; e_rw = rw; e_vrw = vrw; e_mtr = mtr;
        e_alu  = (kind == 1) ? loaded0 : base;
        e_vres = (kind == 3) ? loaded_vec : vd;
        cyc();
    endtask

    logic [31:0] wrap_addr [8];
    logic [255:0] vd_st;

    initial begin
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        rst_n = 1'b0;
        valid_i = 0; RegWrite_i = 0; MemtoReg_i = 0; VRegWrite_i = 0; MemRead_i = 0;
        MemWrite_i = 0; VLoad_i = 0; VStore_i = 0; write_addr_i = '0; alu_result_i = '0;
        store_data_i = '0; vdata_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
        e_stall = 0; e_req = 0; e_rw = 0; e_vrw = 0; e_mtr = 0; e_mtr_chk = 0; e_fld_chk = 0;
        e_we = 0; e_addr = '0; e_wdata = '0; e_alu = '0; e_waddr = '0; e_vres = '0;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ack right after reset and in idle must be ignored
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Non-memory pass-through
        clear_obs();
        do_op(0, 32'h0000_1234, 32'h0, rand256(), 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, -1);
        chk("alu_passthru_value", 256'(last_alu), 256'(32'h1234));
        chk("alu_passthru_regwrite", 256'(last_rw), 256'(1'b1));
        chk("alu_passthru_req", 256'(last_req), 256'(1'b0));
        chk("alu_passthru_stall", 256'(stall_cnt), 256'(0));

        // Scalar load with three wait cycles
        clear_obs();
        do_op(1, 32'h100, 32'h0, rand256(), 5'd7, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, -1);
        chk("sload_stall_cycles", 256'(stall_cnt), 256'(5));
        chk("sload_data", 256'(last_alu), 256'(32'hDEAD_BEEF));
        chk("sload_memtoreg", 256'(last_mtr), 256'(1'b1));
        chk("sload_addr", 256'(obs_addr[0]), 256'(32'h100));

        // Vector load, ack every cycle
        clear_obs();
        do_op(3, 32'h200, 32'h0, rand256(), 5'd3, 1'b0, 1'b0, 1'b1, 0, 32'h10, 1'b0, -1);
        chk("vload_beats", 256'(obs_addr.size()), 256'(8));
        for (int k = 0; k < 8; k++) begin
            chk("vload_addr", 256'(obs_addr[k]), 256'(32'h200 + 32'(4 * k)));
            chk("vload_lane", 256'(last_vres[k*32 +: 32]), 256'(32'h10 + 32'(k)));
        end
        chk("vload_vregwrite_done", 256'(last_vrw), 256'(1'b1));
        chk("vload_vregwrite_stall", 256'(vrw_in_stall), 256'(0));
        chk("vload_stall_cycles", 256'(stall_cnt), 256'(9));

        // Vector store across the 2^32 wrap with random ack gaps
        clear_obs();
        vd_st = rand256();
        do_op(4, 32'hFFFF_FFF8, 32'h0, vd_st, 5'd0, 1'b0, 1'b0, 1'b0, -1, 32'h0, 1'b1, -1);
        chk("vstore_beats", 256'(obs_addr.size()), 256'(8));
        for (int k = 0; k < 8; k++) begin
            chk("vstore_addr", 256'(obs_addr[k]), 256'(wrap_addr[k]));
            chk("vstore_wdata", 256'(obs_wdata[k]), 256'(vd_st[k*32 +: 32]));
            chk("vstore_we", 256'(obs_we[k]), 256'(1'b1));
        end

        // Reset in the middle of a vector load at lane 3, then a scalar store
        clear_obs();
        do_op(3, 32'h400, 32'h0, rand256(), 5'd9, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b1, 3);
        chk("abort_beats", 256'(obs_addr.size()), 256'(3));
        clear_obs();
        do_op(2, 32'h80, 32'hCAFE_F00D, rand256(), 5'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, 1'b1, -1);
        chk("post_reset_store_addr", 256'(obs_addr[0]), 256'(32'h80));
        chk("post_reset_store_data", 256'(obs_wdata[0]), 256'(32'hCAFE_F00D));
        chk("post_reset_store_stall", 256'(stall_cnt), 256'(3));

        // Randomized mix, back-to-back and with idle gaps
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic rw, mtr, vrw;
            kind = int'($urandom_range(4, 0));
            unique case (kind)
                0: begin rw = 1'($urandom); mtr = 1'b0; vrw = 1'($urandom); end
                1: begin rw = 1'b1; mtr = 1'b1; vrw = 1'b0; end
                3: begin rw = 1'b0; mtr = 1'b0; vrw = 1'b1; end
                default: begin rw = 1'b0; mtr = 1'b0; vrw = 1'b0; end
            endcase
            do_op(kind, $urandom, $urandom, rand256(), 5'($urandom), rw, mtr, vrw, -1,
                  32'h0, 1'b1, -1);
            if ($urandom_range(3, 0) == 0) idle(1'($urandom));
        end
        idle(1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
